// File: rtl/sparse_pkg.sv
// Shared types for the sparse index scanner: FSM state encoding and index-width helper.
package sparse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } scan_state_t;

  // Index width for a WIDTH-bit mask; a 1-bit field is kept for degenerate widths.
  function automatic int addr_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sparse_index_scanner_first_one_param.sv
// Combinational priority encoder: index and one-hot of the lowest (or highest) set bit.
// Zero latency; no handshake, pure function of seq.
module first_one_param
  import sparse_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0,
  localparam int ADDR_W   = addr_w(WIDTH)
) (
  input  logic [WIDTH-1:0]  seq,
  output logic [ADDR_W-1:0] addr,
  output logic              has_ones,
  output logic [WIDTH-1:0]  one_hot
);

  always_comb begin
    addr    = '0;
    one_hot = '0;
    has_ones = |seq;
    // The last match in iteration order wins, so the loop direction picks the priority.
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (seq[i]) begin
          addr    = i[ADDR_W-1:0];
          one_hot = '0;
          one_hot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (seq[i]) begin
          addr    = i[ADDR_W-1:0];
          one_hot = '0;
          one_hot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sparse_index_scanner.sv
// Emits the index of every set bit of an accepted mask, one per cycle; first index the cycle after accept.
// Holds out_addr/out_last under out_ready=0; one bubble between masks. SPARSE_SCAN_MSB_FIRST_EN selects highest-first.
module sparse_index_scanner
  import sparse_pkg::*;
#(
  parameter int WIDTH   = 32,
  localparam int ADDR_W = addr_w(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              done
);

`ifdef SPARSE_SCAN_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  scan_state_t       state, state_nxt;
  logic [WIDTH-1:0]  mask_q;
  logic [ADDR_W-1:0] enc_addr;
  logic              enc_has_ones;
  logic [WIDTH-1:0]  enc_one_hot;

  first_one_param #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_enc (
    .seq      (mask_q),
    .addr     (enc_addr),
    .has_ones (enc_has_ones),
    .one_hot  (enc_one_hot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mask_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        mask_q <= in_mask;
      end else if (out_valid && out_ready) begin
        mask_q <= mask_q & ~enc_one_hot;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_addr  = '0;
    out_last  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = (in_mask != '0) ? SCAN : FLUSH;
        end
      end
      SCAN: begin
        out_valid = enc_has_ones;
        out_addr  = enc_addr;
        // Exactly one bit left when the remaining mask equals the selected one-hot.
        out_last  = enc_has_ones && (mask_q == enc_one_hot);
        if (out_ready && out_last) begin
          state_nxt = IDLE;
          done      = rst_n;
        end
      end
      FLUSH: begin
        done      = rst_n;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sparse_index_scanner.sv
// Randomised and directed checks of sparse_index_scanner (WIDTH=8) against a set-bit list model.
module tb_sparse_index_scanner;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mask;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_addr;
  logic       out_last;
  logic       done;

  int errors = 0;
  int checks = 0;

  sparse_index_scanner #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: ordered list of set-bit indices in scan order.
  task automatic expected_indices(input logic [7:0] m, output int q[$]);
    q = {};
`ifdef SPARSE_SCAN_MSB_FIRST_EN
    for (int b = WIDTH - 1; b >= 0; b--) if (m[b]) q.push_back(b);
`else
    for (int b = 0; b < WIDTH; b++) if (m[b]) q.push_back(b);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the final handshake.
  task automatic run_mask(input logic [7:0] m, input int stall, input bit rnd);
    int q[$];
    int cyc;
    expected_indices(m, q);
    in_valid  = 1'b1;
    in_mask   = m;
    out_ready = 1'b0;
    #1;
    chk("idle_in_ready", int'(in_ready), 1);
    chk("idle_out_valid", int'(out_valid), 0);
    chk("idle_done", int'(done), 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_mask  = 8'($urandom);
    if (m == 8'h00) begin
      #1;
      chk("zero_out_valid", int'(out_valid), 0);
      chk("zero_done", int'(done), 1);
      chk("zero_in_ready", int'(in_ready), 0);
      @(posedge clk);
      @(negedge clk);
    end else begin
      cyc = 0;
      while (q.size() > 0 && cyc < 200) begin
        out_ready = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        in_mask   = 8'($urandom);
        #1;
        chk("scan_out_valid", int'(out_valid), 1);
        chk("scan_in_ready", int'(in_ready), 0);
        chk("scan_out_addr", int'(out_addr), q[0]);
        chk("scan_out_last", int'(out_last), (q.size() == 1) ? 1 : 0);
        chk("scan_done", int'(done), (out_ready && q.size() == 1) ? 1 : 0);
        if (out_ready) void'(q.pop_front());
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      if (q.size() != 0) chk("scan_timeout", q.size(), 0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_addr", int'(out_addr), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_done", int'(done), 0);

    run_mask(8'b00101110, 0, 1'b0);
    run_mask(8'b00000000, 0, 1'b0);
    run_mask(8'b10000000, 0, 1'b0);
    run_mask(8'b11111111, 0, 1'b0);
    run_mask(8'b10100000, 3, 1'b0);

    // Reset one cycle into a scan: mask discarded, no done pulse.
    in_valid = 1'b1;
    in_mask  = 8'b11001000;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("midrst_done_during", int'(done), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_done", int'(done), 0);
    run_mask(8'b01000000, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_mask(8'($urandom), $urandom_range(0, 2), 1'b1);
    end

    #1;
    chk("end_in_ready", int'(in_ready), 1);
    chk("end_out_valid", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
